// File: rtl/key_pio_pkg.sv
// Register map for the push-button / switch PIO responder.
package key_pio_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;
endpackage

// File: rtl/key_debounce.sv
// One input bit: 2-flop synchronizer, polarity fix, stable-count debouncer.
// level is the debounced "pressed" state; press pulses on the cycle level rises.
module key_debounce #(
  parameter int DEBOUNCE   = 500000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic pin,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          hit;

  assign hit   = (s2 != level) && (cnt == CW'(DEBOUNCE - 1));
  assign press = hit & s2;

  // Polarity is folded in ahead of the first flop so the cleared sync state
  // means "not pressed" and an idle pin never counts toward a change after reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= ACTIVE_LOW ? ~pin : pin;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (hit) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/avalon_key_pio.sv
// Avalon-MM responder exposing debounced keys: DATA, MASK, W1C EDGE, STAT, level irq.
module avalon_key_pio
  import key_pio_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEBOUNCE   = 500000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);
  logic [WIDTH-1:0] db, press, mask, edge_q, w1c;
  logic [31:0]      rd_mux;
  logic             wdata_unused;

  key_debounce #(.DEBOUNCE(DEBOUNCE), .ACTIVE_LOW(ACTIVE_LOW)) u_deb [WIDTH-1:0] (
    .Clk   (Clk),
    .Reset (Reset),
    .pin   (pins_in),
    .level (db),
    .press (press)
  );

  assign wdata_unused = &{1'b0, avs_writedata};
  assign w1c = (avs_write && avs_address == ADDR_EDGE) ? avs_writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = db;
      ADDR_MASK: rd_mux[WIDTH-1:0] = mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_q;
      default:   rd_mux[0]         = irq;
    endcase
  end

  // A press landing in the same cycle as its W1C survives: set is OR-ed after clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mask         <= '0;
      edge_q       <= '0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      if (avs_write && avs_address == ADDR_MASK) mask <= avs_writedata[WIDTH-1:0];
      edge_q <= (edge_q & ~w1c) | press;
      irq    <= |(edge_q & mask);
      if (avs_read) avs_readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_avalon_key_pio.sv
// Directed bench for avalon_key_pio with DEBOUNCE=8, WIDTH=4, active-low pins.
module tb_avalon_key_pio;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  pins_in = 4'hF;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        irq;

  int total = 0;
  int bad = 0;

  avalon_key_pio #(.WIDTH(4), .DEBOUNCE(8), .ACTIVE_LOW(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .pins_in(pins_in), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .irq(irq)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  // Drive Reset mid-cycle and check outputs clear without a clock edge.
  task automatic async_reset(input string tag);
    @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    chk({tag, "_rdata"}, avs_readdata, 32'h0);
    chk({tag, "_irq"}, {31'b0, irq}, 32'h0);
    tick(2);
    Reset = 1'b0;
  endtask

  // Continuous DATA read from the step; readdata shows DATA one edge late,
  // so the debounced bit (set on the 10th edge) appears after the 11th.
  task automatic step_latency(input string tag, input logic [31:0] exp);
    avs_address = 2'd0; avs_read = 1'b1;
    tick(10);
    chk({tag, "_early"}, avs_readdata, 32'h0);
    tick();
    chk({tag, "_on_time"}, avs_readdata, exp);
    avs_read = 1'b0;
  endtask

  vec_t vecs[12];
  logic [31:0] d;

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 2'd2, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0};
    vecs[5]  = '{1'b0, 2'd1, 32'h0,        32'hF};
    vecs[6]  = '{1'b1, 2'd0, 32'hF,        32'h0};
    vecs[7]  = '{1'b0, 2'd0, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 2'd1, 32'hA,        32'h0};
    vecs[9]  = '{1'b0, 2'd1, 32'h0,        32'hA};
    vecs[10] = '{1'b1, 2'd1, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 2'd1, 32'h0,        32'h0};

    // 1: reset state, async reset clears readdata, register access table
    tick(3);
    chk("rst_rdata", avs_readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    Reset = 1'b0;
    tick(4);
    wr(2'd1, 32'h5);
    rd(2'd1, d);
    chk("pre_rst_mask", d, 32'h5);
    async_reset("t1");
    tick(4);
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
      else begin
        rd(vecs[i].addr, d);
        chk($sformatf("vec%0d", i), d, vecs[i].exp);
      end
    end

    // 2: 5-cycle glitch never reaches DATA or EDGE
    pins_in[0] = 1'b0;
    tick(5);
    pins_in[0] = 1'b1;
    tick(15);
    rd(2'd0, d); chk("glitch_data", d, 32'h0);
    rd(2'd2, d); chk("glitch_edge", d, 32'h0);

    // 3: clean press of bit 2
    pins_in[2] = 1'b0;
    step_latency("press", 32'h4);
    rd(2'd2, d); chk("press_edge", d, 32'h4);
    chk("press_irq_masked", {31'b0, irq}, 32'h0);

    // 4: enabling MASK raises irq one cycle later; W1C drops it
    wr(2'd1, 32'hF);
    chk("irq_reg_delay", {31'b0, irq}, 32'h0);
    tick();
    chk("irq_set", {31'b0, irq}, 32'h1);
    wr(2'd2, 32'h4);
    tick();
    chk("irq_clr", {31'b0, irq}, 32'h0);
    rd(2'd3, d); chk("stat_clr", d, 32'h0);
    rd(2'd2, d); chk("edge_clr", d, 32'h0);

    // 5: press/release bit 1, W1C semantics, then W1C racing a new press
    pins_in[1] = 1'b0; tick(12);
    pins_in[1] = 1'b1; tick(12);
    rd(2'd2, d); chk("b1_edge", d, 32'h2);
    rd(2'd3, d); chk("b1_stat", d, 32'h1);
    wr(2'd2, 32'h0);
    rd(2'd2, d); chk("w1c_zero_keeps", d, 32'h2);
    pins_in[1] = 1'b0;
    tick(9);
    wr(2'd2, 32'h2);
    rd(2'd2, d); chk("race_edge", d, 32'h2);
    chk("race_irq", {31'b0, irq}, 32'h1);
    rd(2'd0, d); chk("race_data", d, 32'h6);

    // 6: release of bit 2 leaves EDGE alone; reset with bit 1 held re-qualifies
    pins_in[2] = 1'b1;
    tick(12);
    rd(2'd0, d); chk("release_data", d, 32'h2);
    rd(2'd2, d); chk("release_edge", d, 32'h2);
    async_reset("t6");
    step_latency("requal", 32'h2);
    rd(2'd2, d); chk("requal_edge", d, 32'h2);
    chk("requal_irq_masked", {31'b0, irq}, 32'h0);
    wr(2'd1, 32'h2);
    tick();
    chk("requal_irq", {31'b0, irq}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
